// File: rtl/clk_switch_seq.sv
// clk_switch_seq: sys_clock-domain sequencer for the CPU clock-mux select.
// Holds the CPU in reset around every select change, waits for a stable
// Clock Wizard lock before switching up, and falls back to sys_clock on
// lock timeout or lock loss.
// Optional feature macro: CLKSEL_LOSS_COUNT_EN (8-bit saturating lock-loss counter).
module clk_switch_seq #(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_STABLE   = 64,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 17
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       req_clk_wiz,
    input  logic       clk_wiz_locked,
    output logic       clk_wiz_enable,
    output logic       cpu_reset,
    output logic       busy,
    output logic       lock_fail,
    output logic       lock_lost,
    output logic [7:0] loss_count
);

    typedef enum logic [3:0] {
        ST_BOOT      = 4'd0,
        ST_SYS       = 4'd1,
        ST_HOLD_UP   = 4'd2,
        ST_WAIT_LOCK = 4'd3,
        ST_SWITCH_UP = 4'd4,
        ST_WIZ       = 4'd5,
        ST_HOLD_DN   = 4'd6,
        ST_SWITCH_DN = 4'd7,
        ST_SETTLE_DN = 4'd8
    } state_t;

    // Terminal counts: a state lasting N cycles leaves when its counter reads N-1.
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    logic             req_meta_r;
    logic             req_s_r;
    logic             lock_meta_r;
    logic             lock_s_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] stable_r;
    logic             loss_event_s;
    logic             timeout_s;
    logic             enable_nxt_s;
    logic             cpu_reset_nxt_s;
    logic             busy_nxt_s;
    logic             lock_fail_nxt_s;
    logic             lock_lost_nxt_s;

    // Two-flop synchronisers for the asynchronous request and lock inputs.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            req_meta_r  <= 1'b0;
            req_s_r     <= 1'b0;
            lock_meta_r <= 1'b0;
            lock_s_r    <= 1'b0;
        end else begin
            req_meta_r  <= req_clk_wiz;
            req_s_r     <= req_meta_r;
            lock_meta_r <= clk_wiz_locked;
            lock_s_r    <= lock_meta_r;
        end
    end

    // State register.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shared state timer: cleared on every state entry, saturates instead of wrapping.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Consecutive synced-lock-high count while waiting; any low sample restarts it.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            stable_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_WAIT_LOCK) && (state_nxt_s == ST_WAIT_LOCK) && lock_s_r) begin
            stable_r <= stable_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stable_r <= {CNT_W{1'b0}};
        end
    end

    // Next-state logic; also flags lock-loss and lock-timeout events.
    always_comb begin
        state_nxt_s  = state_r;
        loss_event_s = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_BOOT: begin
                if (cnt_r == HOLD_LAST) state_nxt_s = ST_SYS;
                else                    state_nxt_s = ST_BOOT;
            end
            ST_SYS: begin
                if (req_s_r && !lock_fail) state_nxt_s = ST_HOLD_UP;
                else                       state_nxt_s = ST_SYS;
            end
            ST_HOLD_UP: begin
                if (cnt_r == HOLD_LAST) state_nxt_s = ST_WAIT_LOCK;
                else                    state_nxt_s = ST_HOLD_UP;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_r && (stable_r == STABLE_LAST)) begin
                    state_nxt_s = ST_SWITCH_UP;
                end else if (!req_s_r) begin
                    state_nxt_s = ST_SETTLE_DN;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_SETTLE_DN;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_SWITCH_UP: begin
                if (cnt_r == SETTLE_LAST) state_nxt_s = ST_WIZ;
                else                      state_nxt_s = ST_SWITCH_UP;
            end
            ST_WIZ: begin
                // Lock loss skips the hold: the CPU clock is already unusable.
                if (!lock_s_r) begin
                    loss_event_s = 1'b1;
                    state_nxt_s  = ST_SWITCH_DN;
                end else if (!req_s_r) begin
                    state_nxt_s = ST_HOLD_DN;
                end else begin
                    state_nxt_s = ST_WIZ;
                end
            end
            ST_HOLD_DN: begin
                if (!lock_s_r) begin
                    loss_event_s = 1'b1;
                    state_nxt_s  = ST_SWITCH_DN;
                end else if (cnt_r == HOLD_LAST) begin
                    state_nxt_s = ST_SWITCH_DN;
                end else begin
                    state_nxt_s = ST_HOLD_DN;
                end
            end
            ST_SWITCH_DN: begin
                state_nxt_s = ST_SETTLE_DN;
            end
            ST_SETTLE_DN: begin
                if (cnt_r == SETTLE_LAST) state_nxt_s = ST_SYS;
                else                      state_nxt_s = ST_SETTLE_DN;
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state register.
    always_comb begin
        enable_nxt_s    = 1'b0;
        cpu_reset_nxt_s = 1'b1;
        busy_nxt_s      = 1'b1;
        case (state_nxt_s)
            ST_SYS: begin
                cpu_reset_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
            ST_WIZ: begin
                enable_nxt_s    = 1'b1;
                cpu_reset_nxt_s = 1'b0;
                busy_nxt_s      = 1'b0;
            end
            ST_SWITCH_UP, ST_HOLD_DN: begin
                enable_nxt_s = 1'b1;
            end
            default: begin
                enable_nxt_s = 1'b0;
            end
        endcase
        // Sticky flags: a new event wins over the clear so it is never missed.
        if (timeout_s)     lock_fail_nxt_s = 1'b1;
        else if (!req_s_r) lock_fail_nxt_s = 1'b0;
        else               lock_fail_nxt_s = lock_fail;
        if (loss_event_s)  lock_lost_nxt_s = 1'b1;
        else if (!req_s_r) lock_lost_nxt_s = 1'b0;
        else               lock_lost_nxt_s = lock_lost;
    end

    // Registered outputs; reset forces sys_clock select and CPU reset immediately.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            clk_wiz_enable <= 1'b0;
            cpu_reset      <= 1'b1;
            busy           <= 1'b1;
            lock_fail      <= 1'b0;
            lock_lost      <= 1'b0;
        end else begin
            clk_wiz_enable <= enable_nxt_s;
            cpu_reset      <= cpu_reset_nxt_s;
            busy           <= busy_nxt_s;
            lock_fail      <= lock_fail_nxt_s;
            lock_lost      <= lock_lost_nxt_s;
        end
    end

`ifdef CLKSEL_LOSS_COUNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating lock-loss event counter; only reset clears it.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            loss_cnt_r <= 8'd0;
        end else if (loss_event_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_count = loss_cnt_r;
`else
    assign loss_count = 8'd0;
`endif

endmodule

// File: tb/tb_clk_switch_seq.sv
// Self-checking bench for clk_switch_seq: a vector table for the nominal
// up/down switch path, then hand-written sequences for lock loss, a lock
// glitch in the stability window, reset during SWITCH_UP and lock timeout.
module tb_clk_switch_seq;

    logic       sys_clock = 1'b0;
    logic       reset;
    logic       req_clk_wiz;
    logic       clk_wiz_locked;
    logic       clk_wiz_enable;
    logic       cpu_reset;
    logic       busy;
    logic       lock_fail;
    logic       lock_lost;
    logic [7:0] loss_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic req;
        logic lock;
        int   cycles;
        logic sel;
        logic crst;
        logic busy;
        logic lf;
        logic ll;
    } vec_t;

    typedef struct {
        string name;
        logic  sel;
        logic  crst;
        logic  busy;
        logic  lf;
        logic  ll;
    } exp_t;

    exp_t sb_q[$];

    clk_switch_seq dut (
        .sys_clock      (sys_clock),
        .reset          (reset),
        .req_clk_wiz    (req_clk_wiz),
        .clk_wiz_locked (clk_wiz_locked),
        .clk_wiz_enable (clk_wiz_enable),
        .cpu_reset      (cpu_reset),
        .busy           (busy),
        .lock_fail      (lock_fail),
        .lock_lost      (lock_lost),
        .loss_count     (loss_count)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge sys_clock);
        #1;
    endtask

    // Watchdog: the whole run is well under this bound.
    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[17];
        exp_t e;
        int   n;
        int   m;
        logic sel_seen;

        // Nominal path: boot, switch up with lock held, switch down on request.
        vecs[0]  = '{1'b0, 1'b0, 15, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // still BOOT
        vecs[1]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // SYS after 16
        vecs[2]  = '{1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // lock alone does nothing
        vecs[3]  = '{1'b1, 1'b1,  2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // request in synchroniser
        vecs[4]  = '{1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // HOLD_UP
        vecs[5]  = '{1'b1, 1'b1, 79, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // hold + stability window
        vecs[6]  = '{1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // SWITCH_UP
        vecs[7]  = '{1'b1, 1'b1,  7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // settling
        vecs[8]  = '{1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // WIZ
        vecs[9]  = '{1'b1, 1'b1, 20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // stays WIZ
        vecs[10] = '{1'b0, 1'b1,  2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // drop request
        vecs[11] = '{1'b0, 1'b1,  1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // HOLD_DN
        vecs[12] = '{1'b0, 1'b1, 15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // still HOLD_DN
        vecs[13] = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // SWITCH_DN
        vecs[14] = '{1'b0, 1'b1,  8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // settling down
        vecs[15] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // SYS
        vecs[16] = '{1'b0, 1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // stays SYS

        reset          = 1'b1;
        req_clk_wiz    = 1'b0;
        clk_wiz_locked = 1'b0;
        step(3);
        check("reset_sel", clk_wiz_enable, 1'b0);
        check("reset_cpu_reset", cpu_reset, 1'b1);
        check("reset_busy", busy, 1'b1);
        check("reset_lock_fail", lock_fail, 1'b0);
        check("reset_lock_lost", lock_lost, 1'b0);
        check("reset_loss_count", loss_count, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            req_clk_wiz    = vecs[i].req;
            clk_wiz_locked = vecs[i].lock;
            e.name = $sformatf("vec%0d", i);
            e.sel  = vecs[i].sel;
            e.crst = vecs[i].crst;
            e.busy = vecs[i].busy;
            e.lf   = vecs[i].lf;
            e.ll   = vecs[i].ll;
            sb_q.push_back(e);
            step(vecs[i].cycles);
            e = sb_q.pop_front();
            check({e.name, ".sel"}, clk_wiz_enable, e.sel);
            check({e.name, ".cpu_reset"}, cpu_reset, e.crst);
            check({e.name, ".busy"}, busy, e.busy);
            check({e.name, ".lock_fail"}, lock_fail, e.lf);
            check({e.name, ".lock_lost"}, lock_lost, e.ll);
        end

        // Lock loss while in WIZ.
        req_clk_wiz = 1'b1;
        n = 0;
        while (!(clk_wiz_enable && !cpu_reset) && n < 200) begin
            step(1);
            n++;
        end
        check("t4_reach_wiz", n < 200, 1'b1);
        clk_wiz_locked = 1'b0;
        step(1);
        clk_wiz_locked = 1'b1;
        n = 1;
        while (clk_wiz_enable && n < 8) begin
            step(1);
            n++;
        end
        check("t4_sel_drop_cycles", n, 3);
        check("t4_lock_lost", lock_lost, 1'b1);
        check("t4_cpu_reset_at_drop", cpu_reset, 1'b1);
`ifdef CLKSEL_LOSS_COUNT_EN
        check("t4_loss_count", loss_count, 8'd1);
`else
        check("t4_loss_count", loss_count, 8'd0);
`endif
        m = 0;
        while (cpu_reset && m < 12) begin
            step(1);
            m++;
        end
        check("t4_release_window", (m >= 8) && (m <= 9), 1'b1);
        req_clk_wiz = 1'b0;
        step(3);
        check("t4_lock_lost_clear", lock_lost, 1'b0);
        n = 0;
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        check("t4_back_to_sys", n < 100, 1'b1);

        // Lock glitch on cycle 63 of the stability window.
        req_clk_wiz = 1'b1;
        step(79);
        clk_wiz_locked = 1'b0;
        step(1);
        clk_wiz_locked = 1'b1;
        step(3);
        check("t5_no_early_switch", clk_wiz_enable, 1'b0);
        step(62);
        check("t5_before_restart_done", clk_wiz_enable, 1'b0);
        step(1);
        check("t5_switch_after_restart", clk_wiz_enable, 1'b1);
        check("t5_cpu_reset_during_switch", cpu_reset, 1'b1);

        // Asynchronous reset while in SWITCH_UP.
        step(2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_sel", clk_wiz_enable, 1'b0);
        check("t6_async_cpu_reset", cpu_reset, 1'b1);
        check("t6_async_busy", busy, 1'b1);
        step(2);
        reset = 1'b0;
        step(15);
        check("t6_boot_hold", cpu_reset, 1'b1);
        check("t6_boot_sel", clk_wiz_enable, 1'b0);
        step(1);
        check("t6_boot_release", cpu_reset, 1'b0);
        step(1);
        check("t6_rerequest_hold", cpu_reset, 1'b1);
        req_clk_wiz = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        check("t6_back_to_sys", n < 100, 1'b1);

        // Lock never arrives: WAIT_LOCK times out.
        clk_wiz_locked = 1'b0;
        step(3);
        req_clk_wiz = 1'b1;
        sel_seen = 1'b0;
        for (int c = 0; c < 65553; c++) begin
            step(1);
            sel_seen = sel_seen | clk_wiz_enable;
        end
        check("t3_before_timeout_flag", lock_fail, 1'b0);
        check("t3_before_timeout_busy", busy, 1'b1);
        step(1);
        check("t3_timeout_flag", lock_fail, 1'b1);
        check("t3_timeout_cpu_reset", cpu_reset, 1'b1);
        sel_seen = sel_seen | clk_wiz_enable;
        step(8);
        check("t3_sys_busy", busy, 1'b0);
        check("t3_sys_cpu_reset", cpu_reset, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(1);
            sel_seen = sel_seen | clk_wiz_enable;
        end
        check("t3_blocked_busy", busy, 1'b0);
        check("t3_sticky_flag", lock_fail, 1'b1);
        check("t3_sel_never_high", sel_seen, 1'b0);
        req_clk_wiz = 1'b0;
        step(3);
        check("t3_flag_cleared", lock_fail, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
